// File: rtl/onn_pkg.sv
// Shared constants and FSM state type for the oscillatory neural network array.
package onn_pkg;

    localparam int NUM_NEURONS    = 15;
    localparam int PHASE_BITS     = 4;
    localparam int STABLE_PERIODS = 4;
    localparam int MAX_PERIODS    = 64;

    localparam int P       = 2 ** PHASE_BITS;
    localparam int HALF    = P / 2;
    localparam int QUARTER = P / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/onn_phase_neuron.sv
// One digital phase oscillator: phase register, nin edge detector, bang-bang
// +/-1 phase correction and square-wave output decode against the shared counter.
module onn_phase_neuron #(
    parameter int PHASE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_load_inphase,
    input  logic                  i_en,
    input  logic [PHASE_BITS-1:0] i_cnt,
    input  logic                  i_nin,
    output logic                  o_nout,
    output logic                  o_upd,
    output logic [PHASE_BITS-1:0] o_phase
);

    localparam logic [PHASE_BITS-1:0] HALF_V = PHASE_BITS'(2 ** (PHASE_BITS - 1));
    localparam logic [PHASE_BITS-1:0] ONE_V  = PHASE_BITS'(1);

    logic [PHASE_BITS-1:0] r_phase;
    logic                  r_nin_q;
    logic [PHASE_BITS-1:0] w_d;
    logic                  w_rise;

    // d's MSB clear means the counter is in the first half-period after our phase.
    assign w_d     = i_cnt - r_phase;
    assign w_rise  = i_nin & ~r_nin_q;
    assign o_nout  = ~w_d[PHASE_BITS-1];
    assign o_upd   = i_en & w_rise & (w_d != '0);
    assign o_phase = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_nin_q <= 1'b0;
        end else begin
            r_nin_q <= i_nin;
            if (i_load) begin
                r_phase <= i_load_inphase ? '0 : HALF_V;
            end else if (o_upd) begin
                r_phase <= w_d[PHASE_BITS-1] ? (r_phase - ONE_V) : (r_phase + ONE_V);
            end
        end
    end

endmodule

// File: rtl/onn_neuron_array.sv
// Oscillator array with shared phase counter, convergence/timeout FSM and pattern readout.
// Define ONN_PHASE_DBG_EN to expose the registered phases on phase_dbg.
module onn_neuron_array
    import onn_pkg::*;
#(
    parameter int NUM_NEURONS    = onn_pkg::NUM_NEURONS,
    parameter int PHASE_BITS     = onn_pkg::PHASE_BITS,
    parameter int STABLE_PERIODS = onn_pkg::STABLE_PERIODS,
    parameter int MAX_PERIODS    = onn_pkg::MAX_PERIODS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [0:NUM_NEURONS-1]           pattern_in,
    input  logic [0:NUM_NEURONS-1]           nin,
    output logic [0:NUM_NEURONS-1]           nout,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [0:NUM_NEURONS-1]           result_pattern
`ifdef ONN_PHASE_DBG_EN
    ,
    output logic [NUM_NEURONS*PHASE_BITS-1:0] phase_dbg
`endif
);

    localparam int SW = $clog2(STABLE_PERIODS + 1);
    localparam int PW = $clog2(MAX_PERIODS + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [PHASE_BITS-1:0] r_cnt;
    logic                  r_warm;
    logic                  r_upd_seen;
    logic [SW-1:0]         r_stable_cnt;
    logic [PW-1:0]         r_periods;
    logic                  r_timeout;
    logic [0:NUM_NEURONS-1] r_result;

    logic                  w_load;
    logic                  w_en;
    logic                  w_period_end;
    logic                  w_upd_period;
    logic [SW-1:0]         w_stable_next;
    logic [PW-1:0]         w_periods_next;
    logic                  w_converged;
    logic                  w_timed_out;
    logic [0:NUM_NEURONS-1] w_upd;
    logic [0:NUM_NEURONS-1] w_result;
    logic [PHASE_BITS-1:0] w_phase [NUM_NEURONS];

    assign w_load = (r_state == IDLE) && start;
    assign w_en   = (r_state == RUN) && !r_warm;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
            logic [PHASE_BITS-1:0] w_diff;

            onn_phase_neuron #(
                .PHASE_BITS(PHASE_BITS)
            ) u_neuron (
                .clk            (clk),
                .rst            (rst),
                .i_load         (w_load),
                .i_load_inphase (pattern_in[gi]),
                .i_en           (w_en),
                .i_cnt          (r_cnt),
                .i_nin          (nin[gi]),
                .o_nout         (nout[gi]),
                .o_upd          (w_upd[gi]),
                .o_phase        (w_phase[gi])
            );

            // Within a quarter period of neuron 0 either way <=> top two diff bits equal.
            assign w_diff       = w_phase[gi] - w_phase[0];
            assign w_result[gi] = (w_diff[PHASE_BITS-1] == w_diff[PHASE_BITS-2]);

`ifdef ONN_PHASE_DBG_EN
            assign phase_dbg[gi*PHASE_BITS +: PHASE_BITS] = w_phase[gi];
`endif
        end
    endgenerate

    assign w_period_end   = (r_state == RUN) && (r_cnt == '1);
    assign w_upd_period   = r_upd_seen | (|w_upd);
    assign w_stable_next  = w_upd_period ? '0 : (r_stable_cnt + SW'(1));
    assign w_periods_next = r_periods + PW'(1);
    assign w_converged    = w_period_end && !r_warm && (w_stable_next == SW'(STABLE_PERIODS));
    assign w_timed_out    = w_period_end && !r_warm && (w_periods_next == PW'(MAX_PERIODS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_converged || w_timed_out) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == RUN);
        done    = (r_state == DONE);
        timeout = (r_state == DONE) && r_timeout;
    end

    assign result_pattern = r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_warm       <= 1'b0;
            r_upd_seen   <= 1'b0;
            r_stable_cnt <= '0;
            r_periods    <= '0;
            r_timeout    <= 1'b0;
            r_result     <= '0;
        end else if (w_load) begin
            r_cnt        <= '0;
            r_warm       <= 1'b1;
            r_upd_seen   <= 1'b0;
            r_stable_cnt <= '0;
            r_periods    <= '0;
            r_timeout    <= 1'b0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + PHASE_BITS'(1);
            if (w_period_end) begin
                r_upd_seen <= 1'b0;
                if (r_warm) begin
                    r_warm <= 1'b0;
                end else begin
                    r_stable_cnt <= w_stable_next;
                    r_periods    <= w_periods_next;
                end
            end else begin
                r_upd_seen <= w_upd_period;
            end
            if (w_converged || w_timed_out) begin
                r_result  <= w_result;
                r_timeout <= !w_converged;
            end
        end
    end

endmodule

// File: tb/tb_onn_neuron_array.sv
// Scoreboard bench: each run pushes its expected done latency/timeout/result; a monitor checks on done.
`timescale 1ns/1ps
module tb_onn_neuron_array;

    localparam int N = 15;
    localparam logic [0:N-1] ALL1 = 15'b111111111111111;
    localparam logic [0:N-1] PAT2 = 15'b110010111001011;
    localparam logic [0:N-1] PAT3 = 15'b101111010011101;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [0:N-1]   pattern_in;
    logic [0:N-1]   nin;
    logic [0:N-1]   nout;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [0:N-1]   result_pattern;
`ifdef ONN_PHASE_DBG_EN
    logic [N*4-1:0] phase_dbg;
`endif

    logic           drive_mode;
    logic [0:N-1]   nin_drv;
    logic [0:N-1]   flip;

    assign nin = drive_mode ? nin_drv : (nout ^ flip);

    always #5 clk = ~clk;

    onn_neuron_array dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pattern_in     (pattern_in),
        .nin            (nin),
        .nout           (nout),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .result_pattern (result_pattern)
`ifdef ONN_PHASE_DBG_EN
        ,
        .phase_dbg      (phase_dbg)
`endif
    );

    typedef struct {
        int           cycles;
        logic         to;
        logic [0:N-1] res;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    int   passes = 0;
    int   checks = 0;
    int   n_done = 0;
    int   cyc    = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kick(input logic [0:N-1] p);
        @(negedge clk);
        pattern_in = p;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (n_done < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (n_done >= target) passes++;
        else $display("FAIL wait_done%0d: got %0d done pulses want %0d", target, n_done, target);
    endtask

    // Monitor: cycle count since busy rose, scoreboard pop on every done pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) cyc = 0;
            else cyc++;
            busy_prev = busy;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done=1 want no pending run");
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("run%0d_cycles", e.id), 64'(cyc), 64'(e.cycles));
                    check($sformatf("run%0d_timeout", e.id), 64'(timeout), 64'(e.to));
                    check($sformatf("run%0d_result", e.id), 64'(result_pattern), 64'(e.res));
                    check($sformatf("run%0d_busy_low", e.id), 64'(busy), 64'd0);
                    $display("txn run%0d: cycles=%0d timeout=%b result=%b", e.id, cyc, timeout, result_pattern);
                end
                n_done++;
            end
        end
    end

    initial begin : toggler
        forever begin
            @(negedge clk);
            if (drive_mode) nin_drv = ~nin_drv;
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pattern_in = '0;
        drive_mode = 1'b0;
        nin_drv    = '0;
        flip       = '0;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        check("reset_nout", 64'(nout), 64'(ALL1));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        check("reset_result", 64'(result_pattern), 64'd0);
        $display("txn reset: nout=%b busy=%b done=%b", nout, busy, done);

        // Looped synapse, no disturbance: converge after warm-up + 4 quiet periods.
        exp_q.push_back('{80, 1'b0, PAT2, 1});
        kick(PAT2);
        wait_done(1, 200);

        // Forced rises: neuron 3 at d=2 in period 1, neuron 5 at d=12 in period 2.
        exp_q.push_back('{112, 1'b0, PAT3, 2});
        kick(PAT3);
        cycles(17);
        flip[3] = 1'b1;
        cycles(1);
        flip[3] = 1'b0;
        cycles(1);
`ifdef ONN_PHASE_DBG_EN
        check("phase3_after_rise", 64'(phase_dbg[3*4 +: 4]), 64'd1);
`endif
        cycles(25);
        flip[5] = 1'b1;
        cycles(1);
        flip[5] = 1'b0;
        cycles(2);
        check("nout5_shifted", 64'(nout[5]), 64'd1);
`ifdef ONN_PHASE_DBG_EN
        check("phase5_wrapped", 64'(phase_dbg[5*4 +: 4]), 64'd15);
`endif
        cycles(1);
        check("nout3_shifted", 64'(nout[3]), 64'd0);
        $display("txn forced_rises: nout3=%b nout5_prev=%b", nout[3], nout[5]);
        wait_done(2, 200);

        // Toggling nin keeps updates coming every period -> timeout; mid-run start ignored.
        drive_mode = 1'b1;
        exp_q.push_back('{1040, 1'b1, ALL1, 3});
        kick(ALL1);
        cycles(200);
        kick(PAT2);
        wait_done(3, 1200);
        drive_mode = 1'b0;

        // Reset mid-run aborts at once; a fresh run afterwards converges normally.
        kick(PAT2);
        cycles(30);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_nout", 64'(nout), 64'(ALL1));
        check("abort_done", 64'(done), 64'd0);
        $display("txn abort: busy=%b nout=%b", busy, nout);
        cycles(2);
        rst = 1'b0;
        exp_q.push_back('{80, 1'b0, PAT2, 4});
        kick(PAT2);
        wait_done(4, 200);

        cycles(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
